// File: rtl/instr_fetch_ctrl_if.sv
// Decode-side handshake of the instruction fetch sequencer: {pc, instr} offered with valid/ready.
// The master side is the fetch unit; the slave side is decode.
interface instr_fetch_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// RV32I instruction fetch sequencer: owns the PC, prefetches from a combinational ROM into a
// small FIFO and re-steers on redirects. Define FETCH_PERF_CNT_EN to add the perf counter outputs.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [31:0]                   instr_addr,
  input  logic [31:0]                   instr_data,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  instr_fetch_ctrl_if.master            dec,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_fetch_cnt,
  output logic [31:0]                   perf_flush_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  logic [31:0]   fetch_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [31:0]   ent_pc    [FIFO_DEPTH];
  logic [31:0]   ent_instr [FIFO_DEPTH];

  logic          vld_p0;
  logic          full;
  logic          pop;
  logic          push;

  always_comb begin
    vld_p0 = (count != '0);
    full   = (count == DEPTH_C);
    pop    = vld_p0 & dec.out_ready;
    // A full FIFO still accepts a new word when the head leaves in the same cycle.
    push   = fetch_en & ~redirect_valid & (~full | pop);
  end

  // Fetch stage: PC, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= pc_align(redirect_pc);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= pc_inc(fetch_pc);
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Prefetch storage: data only, qualified by count so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc[wr_ptr]    <= fetch_pc;
      ent_instr[wr_ptr] <= instr_data;
    end
  end

  // Decode stage: head of the FIFO
  always_comb begin
    instr_addr    = fetch_pc;
    fifo_count    = count;
    dec.out_valid = vld_p0;
    dec.out_pc    = vld_p0 ? ent_pc[rd_ptr]    : 32'h0000_0000;
    dec.out_instr = vld_p0 ? ent_instr[rd_ptr] : NOP;
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall;

  always_comb begin
    stall = fetch_en & ~redirect_valid & full & ~pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push)           perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (stall)          perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table, hand sequences for reset/wrap corners,
// and randomized traffic against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [31:0] addr0, data0, rpc0;
  logic        en0, rv0, rdy0;
  logic [2:0]  cnt0;
  logic [31:0] addr1, data1, rpc1;
  logic        en1, rv1, rdy1;
  logic [2:0]  cnt1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf0, pl0, ps0, pf1, pl1, ps1;
`endif

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0011_0233;
      32'h0000_0004: return 32'h4011_02B3;
      32'h0000_007C: return 32'h0000_0013;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endcase
  endfunction

  instr_fetch_ctrl_if dif0 ();
  instr_fetch_ctrl_if dif1 ();

  assign data0 = rom(addr0);
  assign data1 = rom(addr1);
  assign dif0.out_ready = rdy0;
  assign dif1.out_ready = rdy1;

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .instr_addr(addr0), .instr_data(data0),
    .fetch_en(en0), .redirect_valid(rv0), .redirect_pc(rpc0), .dec(dif0),
    .fifo_count(cnt0)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(pf0), .perf_flush_cnt(pl0), .perf_stall_cnt(ps0)
`endif
  );

  instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .instr_addr(addr1), .instr_data(data1),
    .fetch_en(en1), .redirect_valid(rv1), .redirect_pc(rpc1), .dec(dif1),
    .fifo_count(cnt1)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(pf1), .perf_flush_cnt(pl1), .perf_stall_cnt(ps1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step0(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
    en0 = en; rdy0 = rdy; rv0 = rv; rpc0 = rpc;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en, rdy, rv;
    logic [31:0] rpc;
    logic        vld;
    logic [31:0] pc, ins;
    logic [2:0]  cnt;
    logic [31:0] addr;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic vld, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [2:0] cnt, input logic [31:0] addr);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.vld = vld; v.pc = pc; v.ins = ins; v.cnt = cnt; v.addr = addr;
    return v;
  endfunction

  vec_t tbl [20];

  // Reference model: FIFO contents as a queue of {pc, instr}
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  int unsigned m_fetch, m_flush, m_stall;

  task automatic model_reset(input logic [31:0] rpc);
    mq.delete();
    m_pc = rpc; m_fetch = 0; m_flush = 0; m_stall = 0;
  endtask

  task automatic model_edge(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
    bit   do_pop, do_push, is_full;
    ent_t e;
    if (rv) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
      m_flush++;
    end else begin
      do_pop  = (mq.size() != 0) && rdy;
      is_full = (mq.size() == DEPTH);
      do_push = en && (!is_full || do_pop);
      if (en && is_full && !do_pop) m_stall++;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc = m_pc; e.ins = rom(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
        m_fetch++;
      end
    end
  endtask

  task automatic model_check(input int cyc);
    logic        ev;
    logic [31:0] epc, eins;
    ev   = (mq.size() != 0);
    epc  = ev ? mq[0].pc  : 32'h0;
    eins = ev ? mq[0].ins : NOP;
    chk($sformatf("rand%0d_valid", cyc), 64'(dif0.out_valid), 64'(ev));
    chk($sformatf("rand%0d_pc", cyc),    64'(dif0.out_pc),    64'(epc));
    chk($sformatf("rand%0d_instr", cyc), 64'(dif0.out_instr), 64'(eins));
    chk($sformatf("rand%0d_count", cyc), 64'(cnt0),           64'(mq.size()));
    chk($sformatf("rand%0d_addr", cyc),  64'(addr0),          64'(m_pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        r_en, r_rdy, r_rv;
    logic [31:0] r_rpc;

    tbl[0]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  rom(32'h00), 3'd1, 32'h04);
    tbl[1]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  rom(32'h00), 3'd2, 32'h08);
    tbl[2]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  rom(32'h00), 3'd3, 32'h0C);
    tbl[3]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  rom(32'h00), 3'd4, 32'h10);
    tbl[4]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  rom(32'h00), 3'd4, 32'h10);
    tbl[5]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  rom(32'h00), 3'd4, 32'h10);
    tbl[6]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  rom(32'h00), 3'd4, 32'h10);
    tbl[7]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  rom(32'h00), 3'd4, 32'h10);
    tbl[8]  = mk(1, 1, 0, 32'h0,   1, 32'h04,  rom(32'h04), 3'd4, 32'h14);
    tbl[9]  = mk(1, 1, 0, 32'h0,   1, 32'h08,  rom(32'h08), 3'd4, 32'h18);
    tbl[10] = mk(1, 1, 0, 32'h0,   1, 32'h0C,  rom(32'h0C), 3'd4, 32'h1C);
    tbl[11] = mk(1, 1, 0, 32'h0,   1, 32'h10,  rom(32'h10), 3'd4, 32'h20);
    tbl[12] = mk(1, 1, 1, 32'h74,  0, 32'h00,  NOP,         3'd0, 32'h74);
    tbl[13] = mk(1, 1, 0, 32'h0,   1, 32'h74,  rom(32'h74), 3'd1, 32'h78);
    tbl[14] = mk(1, 1, 0, 32'h0,   1, 32'h78,  rom(32'h78), 3'd1, 32'h7C);
    tbl[15] = mk(1, 1, 1, 32'h7E,  0, 32'h00,  NOP,         3'd0, 32'h7C);
    tbl[16] = mk(1, 1, 0, 32'h0,   1, 32'h7C,  32'h13,      3'd1, 32'h80);
    tbl[17] = mk(0, 1, 0, 32'h0,   0, 32'h00,  NOP,         3'd0, 32'h80);
    tbl[18] = mk(0, 1, 1, 32'h200, 0, 32'h00,  NOP,         3'd0, 32'h200);
    tbl[19] = mk(1, 1, 0, 32'h0,   1, 32'h200, rom(32'h200), 3'd1, 32'h204);

    reset = 1'b0;
    en0 = 0; rdy0 = 0; rv0 = 0; rpc0 = '0;
    en1 = 0; rdy1 = 0; rv1 = 0; rpc1 = '0;

    #12;
    chk("rst_valid", 64'(dif0.out_valid), 64'(0));
    chk("rst_instr", 64'(dif0.out_instr), 64'(NOP));
    chk("rst_pc",    64'(dif0.out_pc),    64'(0));
    chk("rst_count", 64'(cnt0),           64'(0));
    chk("rst_addr",  64'(addr0),          64'(0));
    chk("rst_addr1", 64'(addr1),          64'(32'hFFFF_FFF8));
    #1 reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step0(tbl[i].en, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("vec%0d_valid", i), 64'(dif0.out_valid), 64'(tbl[i].vld));
      chk($sformatf("vec%0d_pc", i),    64'(dif0.out_pc),    64'(tbl[i].pc));
      chk($sformatf("vec%0d_instr", i), 64'(dif0.out_instr), 64'(tbl[i].ins));
      chk($sformatf("vec%0d_count", i), 64'(cnt0),           64'(tbl[i].cnt));
      chk($sformatf("vec%0d_addr", i),  64'(addr0),          64'(tbl[i].addr));
    end

    // Asynchronous reset between edges, then restart from RESET_PC
    step0(1, 0, 0, 32'h0);
    step0(1, 0, 0, 32'h0);
    #3 reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(dif0.out_valid), 64'(0));
    chk("midrst_addr",  64'(addr0),          64'(0));
    chk("midrst_count", 64'(cnt0),           64'(0));
    chk("midrst_pc",    64'(dif0.out_pc),    64'(0));
    #1 reset = 1'b1;
    step0(1, 1, 0, 32'h0);
    chk("resume0_pc",    64'(dif0.out_pc),    64'(32'h0));
    chk("resume0_instr", 64'(dif0.out_instr), 64'(32'h0011_0233));
    step0(1, 1, 0, 32'h0);
    chk("resume1_pc",    64'(dif0.out_pc),    64'(32'h4));
    chk("resume1_instr", 64'(dif0.out_instr), 64'(32'h4011_02B3));
    step0(1, 1, 0, 32'h0);
    chk("resume2_pc",    64'(dif0.out_pc),    64'(32'h8));
    chk("resume2_valid", 64'(dif0.out_valid), 64'(1));

    // PC wrap-around on the second instance
    en0 = 0; rdy0 = 0;
    #2 reset = 1'b0;
    #1;
    chk("wrap_rst_addr",  64'(addr1),          64'(32'hFFFF_FFF8));
    chk("wrap_rst_valid", 64'(dif1.out_valid), 64'(0));
    #1 reset = 1'b1;
    en1 = 1; rdy1 = 1;
    @(posedge clk); #1;
    chk("wrap0_pc",    64'(dif1.out_pc),    64'(32'hFFFF_FFF8));
    chk("wrap0_instr", 64'(dif1.out_instr), 64'(rom(32'hFFFF_FFF8)));
    @(posedge clk); #1;
    chk("wrap1_pc",    64'(dif1.out_pc),    64'(32'hFFFF_FFFC));
    @(posedge clk); #1;
    chk("wrap2_pc",    64'(dif1.out_pc),    64'(32'h0000_0000));
    chk("wrap2_instr", 64'(dif1.out_instr), 64'(32'h0011_0233));
    chk("wrap2_addr",  64'(addr1),          64'(32'h0000_0004));
`ifdef FETCH_PERF_CNT_EN
    chk("wrap_perf_fetch", 64'(pf1), 64'(3));
    chk("wrap_perf_flush", 64'(pl1), 64'(0));
    chk("wrap_perf_stall", 64'(ps1), 64'(0));
`endif
    en1 = 0; rdy1 = 0;

    // Randomized traffic against the reference model
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    model_reset(32'h0);
    for (int c = 0; c < 400; c++) begin
      r_en  = ($urandom_range(99) < 80);
      r_rdy = ($urandom_range(99) < 55);
      r_rv  = ($urandom_range(99) < 8);
      r_rpc = $urandom();
      model_edge(r_en, r_rdy, r_rv, r_rpc);
      step0(r_en, r_rdy, r_rv, r_rpc);
      model_check(c);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("rand_perf_fetch", 64'(pf0), 64'(m_fetch));
    chk("rand_perf_flush", 64'(pl0), 64'(m_flush));
    chk("rand_perf_stall", 64'(ps0), 64'(m_stall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Instruction fetch sequencer for the RV32I core.
- Owns the program counter and drives the address of the combinational instruction ROM (word index = addr[31:2]).
- Buffers fetched words in a small prefetch FIFO.
- Hands {pc, instr} to decode over a valid/ready handshake.
- Flushes and re-steers on jal/jalr/branch redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4, prefetch entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- instr_addr  output  32  ROM address; always equals fetch_pc
- instr_data  input  32  ROM read data, valid the same cycle as instr_addr
- fetch_en  input  1  global fetch enable; 0 halts fetching only
- redirect_valid  input  1  one-cycle control-flow redirect strobe
- redirect_pc  input  32  redirect target address
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  decode accepts the head
- out_instr  output  32  head instruction; 32'h0000_0013 (NOP) when empty
- out_pc  output  32  head PC; 0 when empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - fetch_pc=RESET_PC; rd_ptr=wr_ptr=count=0.
  - out_valid=0, out_instr=NOP, out_pc=0, fifo_count=0.
- instr_addr = fetch_pc (registered). instr_data is captured at the edge; no extra ROM latency.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count<FIFO_DEPTH | pop).
- On push: entry[wr_ptr] <= {fetch_pc, instr_data}; fetch_pc <= fetch_pc+4; wr_ptr wraps modulo FIFO_DEPTH.
- PC wrap-around: 32'hFFFF_FFFC + 4 -> 0. There is no fault.
- Full with a simultaneous pop: push still allowed; count unchanged; throughput is 1 instr/cycle.
- Full without a pop: no push; fetch_pc and instr_addr hold.
- Empty: out_valid=0. A push and a pop can never coincide here, because out_valid is registered state and the FIFO has no bypass.
- Latency:
  - Reset release -> first out_valid: 1 edge.
  - Steady state: 1 instr/cycle when out_ready=1.
- out_valid = (count!=0). out_instr/out_pc are muxed from entry[rd_ptr].
- Redirect (redirect_valid=1 at the edge) takes priority over push and pop:
  - count, rd_ptr and wr_ptr cleared.
  - fetch_pc <= {redirect_pc[31:2],2'b00}; misaligned low bits are silently dropped.
  - Any pop asserted that cycle is discarded.
  - out_valid=0 for the following cycle. The target appears at out_pc one edge later (redirect -> target valid = 2 edges).
- fetch_en=0: no push; fetch_pc holds; pops and redirects still operate.
- Redirect while fetch_en=0: fetch_pc is updated; fetching resumes from the target when fetch_en returns.
- Back-to-back redirects: the last one wins; each one flushes.
- Internal states: RUN (fetching), STALL (full or fetch_en=0), FLUSH (cycle after redirect, FIFO empty). All are derived from the registers above; no extra state register is required beyond these.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - Extra outputs perf_fetch_cnt[31:0] (increments on each push), perf_flush_cnt[31:0] (increments on each redirect) and perf_stall_cnt[31:0] (increments each cycle with fetch_en=1, ~redirect_valid, full, ~pop).
  - All three reset to 0 with reset and wrap at 2^32.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, fetch_en=1, out_ready=1 -> out_pc 0x0,0x4,0x8 on consecutive cycles with out_instr 0x00110233, 0x401102B3, ...; out_valid first high 1 edge after release.
- out_ready=0 for 8 cycles -> fifo_count saturates at 4, instr_addr holds 0x10. Then out_ready=1 -> out_pc 0x0,0x4,0x8,0xC,0x10 with no bubble.
- FIFO full, out_ready=1, redirect_valid pulse with redirect_pc=0x74 -> next cycle out_valid=0, fifo_count=0; following cycle out_pc=0x74, then 0x78.
- Redirect to 0x7E -> out_pc=0x7C, out_instr=0x00000013.
- Reset asserted mid-stream between edges -> out_valid=0 and instr_addr=RESET_PC immediately; first fetch resumes from RESET_PC after release.
- RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000. With FETCH_PERF_CNT_EN, perf_fetch_cnt=3 after those three pushes.
